zap_regf_port_sequencer: RTL and testbench



---
 rtl/zap_regf_port_sequencer.sv | 173 +++++++++++++++++
 tb/tb_zap_regf_port_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zap_regf_port_sequencer.sv
// Serialises a combined register-file request (two writebacks, four operand reads)
// onto a 2W/1R registered block RAM and returns the four operands together.
module zap_regf_port_sequencer #(
  parameter int DATA_WDT = 32,
  parameter int ADDR_WDT = 6
) (
  input  logic                i_clk_2x,
  input  logic                i_reset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [ADDR_WDT-1:0] i_rd_addr_0,
  input  logic [ADDR_WDT-1:0] i_rd_addr_1,
  input  logic [ADDR_WDT-1:0] i_rd_addr_2,
  input  logic [ADDR_WDT-1:0] i_rd_addr_3,
  input  logic                i_wr_en_0,
  input  logic                i_wr_en_1,
  input  logic [ADDR_WDT-1:0] i_wr_addr_0,
  input  logic [ADDR_WDT-1:0] i_wr_addr_1,
  input  logic [DATA_WDT-1:0] i_wr_data_0,
  input  logic [DATA_WDT-1:0] i_wr_data_1,
  output logic [DATA_WDT-1:0] o_rd_data_0,
  output logic [DATA_WDT-1:0] o_rd_data_1,
  output logic [DATA_WDT-1:0] o_rd_data_2,
  output logic [DATA_WDT-1:0] o_rd_data_3,
  output logic                o_rd_valid,
  output logic [ADDR_WDT-1:0] o_ram_addr_a,
  output logic [ADDR_WDT-1:0] o_ram_addr_b,
  output logic                o_ram_wen,
  output logic [DATA_WDT-1:0] o_ram_wr_data_a,
  output logic [DATA_WDT-1:0] o_ram_wr_data_b,
  input  logic [DATA_WDT-1:0] i_ram_rd_data
);

  typedef enum logic [2:0] {IDLE, WR, RD0, RD1, RD2, RD3, CAP} state_t;

  state_t state, state_nxt;

  logic [ADDR_WDT-1:0] rd_addr_q [4];
  logic                accept;

  logic                wr_wen;
  logic [ADDR_WDT-1:0] wr_addr_a, wr_addr_b;
  logic [DATA_WDT-1:0] wr_data_a, wr_data_b;

  logic                ram_wen_nxt;
  logic [ADDR_WDT-1:0] ram_addr_a_nxt, ram_addr_b_nxt;
  logic [DATA_WDT-1:0] ram_data_a_nxt, ram_data_b_nxt;
  logic                rd_valid_nxt;

  assign o_req_ready = (state == IDLE);
  assign accept      = i_req_valid && o_req_ready;

  // Duplicate addresses and single writes drive both ports identically so the
  // RAM never sees two different values for one address in the same cycle.
  always_comb begin
    wr_wen    = i_wr_en_0 | i_wr_en_1;
    wr_addr_a = '0;
    wr_addr_b = '0;
    wr_data_a = '0;
    wr_data_b = '0;
    unique case ({i_wr_en_1, i_wr_en_0})
      2'b11: begin
        if (i_wr_addr_0 != i_wr_addr_1) begin
          wr_addr_a = i_wr_addr_0;
          wr_data_a = i_wr_data_0;
        end else begin
          wr_addr_a = i_wr_addr_1;
          wr_data_a = i_wr_data_1;
        end
        wr_addr_b = i_wr_addr_1;
        wr_data_b = i_wr_data_1;
      end
      2'b01: begin
        wr_addr_a = i_wr_addr_0;
        wr_data_a = i_wr_data_0;
        wr_addr_b = i_wr_addr_0;
        wr_data_b = i_wr_data_0;
      end
      2'b10: begin
        wr_addr_a = i_wr_addr_1;
        wr_data_a = i_wr_data_1;
        wr_addr_b = i_wr_addr_1;
        wr_data_b = i_wr_data_1;
      end
      default: ;
    endcase
  end

  // RAM-side values are computed for the state being entered, then registered.
  always_comb begin
    state_nxt      = state;
    ram_wen_nxt    = 1'b0;
    ram_addr_a_nxt = '0;
    ram_addr_b_nxt = '0;
    ram_data_a_nxt = '0;
    ram_data_b_nxt = '0;
    rd_valid_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_req_valid) begin
          state_nxt      = WR;
          ram_wen_nxt    = wr_wen;
          ram_addr_a_nxt = wr_addr_a;
          ram_addr_b_nxt = wr_addr_b;
          ram_data_a_nxt = wr_data_a;
          ram_data_b_nxt = wr_data_b;
        end
      end
      WR: begin
        state_nxt      = RD0;
        ram_addr_a_nxt = rd_addr_q[0];
      end
      RD0: begin
        state_nxt      = RD1;
        ram_addr_a_nxt = rd_addr_q[1];
      end
      RD1: begin
        state_nxt      = RD2;
        ram_addr_a_nxt = rd_addr_q[2];
      end
      RD2: begin
        state_nxt      = RD3;
        ram_addr_a_nxt = rd_addr_q[3];
      end
      RD3: state_nxt = CAP;
      CAP: begin
        state_nxt    = IDLE;
        rd_valid_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_2x) begin
    if (i_reset) begin
      state           <= IDLE;
      o_rd_valid      <= 1'b0;
      o_ram_wen       <= 1'b0;
      o_ram_addr_a    <= '0;
      o_ram_addr_b    <= '0;
      o_ram_wr_data_a <= '0;
      o_ram_wr_data_b <= '0;
      o_rd_data_0     <= '0;
      o_rd_data_1     <= '0;
      o_rd_data_2     <= '0;
      o_rd_data_3     <= '0;
      for (int unsigned k = 0; k < 4; k++) rd_addr_q[k] <= '0;
    end else begin
      state           <= state_nxt;
      o_rd_valid      <= rd_valid_nxt;
      o_ram_wen       <= ram_wen_nxt;
      o_ram_addr_a    <= ram_addr_a_nxt;
      o_ram_addr_b    <= ram_addr_b_nxt;
      o_ram_wr_data_a <= ram_data_a_nxt;
      o_ram_wr_data_b <= ram_data_b_nxt;
      if (accept) begin
        rd_addr_q[0] <= i_rd_addr_0;
        rd_addr_q[1] <= i_rd_addr_1;
        rd_addr_q[2] <= i_rd_addr_2;
        rd_addr_q[3] <= i_rd_addr_3;
      end
      // Read data lags its address by one cycle, so operand k lands in RD(k+1)/CAP.
      unique case (state)
        RD1:     o_rd_data_0 <= i_ram_rd_data;
        RD2:     o_rd_data_1 <= i_ram_rd_data;
        RD3:     o_rd_data_2 <= i_ram_rd_data;
        CAP:     o_rd_data_3 <= i_ram_rd_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zap_regf_port_sequencer.sv
// Directed bench for zap_regf_port_sequencer against a behavioural 2W/1R registered RAM.
module tb_zap_regf_port_sequencer;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [5:0]  i_rd_addr_0, i_rd_addr_1, i_rd_addr_2, i_rd_addr_3;
  logic        i_wr_en_0, i_wr_en_1;
  logic [5:0]  i_wr_addr_0, i_wr_addr_1;
  logic [31:0] i_wr_data_0, i_wr_data_1;
  logic [31:0] o_rd_data_0, o_rd_data_1, o_rd_data_2, o_rd_data_3;
  logic        o_rd_valid;
  logic [5:0]  o_ram_addr_a, o_ram_addr_b;
  logic        o_ram_wen;
  logic [31:0] o_ram_wr_data_a, o_ram_wr_data_b;
  logic [31:0] i_ram_rd_data;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  zap_regf_port_sequencer #(.DATA_WDT(32), .ADDR_WDT(6)) dut (
    .i_clk_2x(clk), .i_reset(i_reset), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_rd_addr_0(i_rd_addr_0), .i_rd_addr_1(i_rd_addr_1),
    .i_rd_addr_2(i_rd_addr_2), .i_rd_addr_3(i_rd_addr_3),
    .i_wr_en_0(i_wr_en_0), .i_wr_en_1(i_wr_en_1),
    .i_wr_addr_0(i_wr_addr_0), .i_wr_addr_1(i_wr_addr_1),
    .i_wr_data_0(i_wr_data_0), .i_wr_data_1(i_wr_data_1),
    .o_rd_data_0(o_rd_data_0), .o_rd_data_1(o_rd_data_1),
    .o_rd_data_2(o_rd_data_2), .o_rd_data_3(o_rd_data_3),
    .o_rd_valid(o_rd_valid),
    .o_ram_addr_a(o_ram_addr_a), .o_ram_addr_b(o_ram_addr_b), .o_ram_wen(o_ram_wen),
    .o_ram_wr_data_a(o_ram_wr_data_a), .o_ram_wr_data_b(o_ram_wr_data_b),
    .i_ram_rd_data(i_ram_rd_data)
  );

  // Register-file RAM: port b written after port a; registered read on port a.
  logic [31:0] mem [64];
  logic        ram_clr;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      i_ram_rd_data <= '0;
    end else begin
      if (o_ram_wen) begin
        mem[o_ram_addr_a] <= o_ram_wr_data_a;
        mem[o_ram_addr_b] <= o_ram_wr_data_b;
      end
      i_ram_rd_data <= mem[o_ram_addr_a];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Contents the directed writes leave behind, by hand.
  function automatic logic [31:0] exp_mem(input logic [5:0] a);
    case (a)
      6'd3:    return 32'h0F0F0F0F;
      6'd5:    return 32'hDEADBEEF;
      6'd7:    return 32'h5555FFFF;
      6'd9:    return 32'h12345678;
      default: return 32'h0;
    endcase
  endfunction

  task automatic scramble_inputs();
    i_req_valid = 1'b0;
    i_wr_en_0 = 1'b1; i_wr_en_1 = 1'b1;
    i_wr_addr_0 = 6'h3E; i_wr_addr_1 = 6'h3D;
    i_wr_data_0 = 32'hBAD0BAD0; i_wr_data_1 = 32'hBAD1BAD1;
    i_rd_addr_0 = 6'h3F; i_rd_addr_1 = 6'h3F; i_rd_addr_2 = 6'h3F; i_rd_addr_3 = 6'h3F;
  endtask

  // One full transaction; returns at the negedge of c8.
  task automatic txn(input logic e0, input logic e1,
                     input logic [5:0] wa0, input logic [5:0] wa1,
                     input logic [31:0] wd0, input logic [31:0] wd1,
                     input logic [5:0] r0, input logic [5:0] r1,
                     input logic [5:0] r2, input logic [5:0] r3,
                     input logic xwen, input logic [5:0] xa, input logic [5:0] xb,
                     input logic [31:0] xda, input logic [31:0] xdb,
                     input logic [31:0] x0, input logic [31:0] x1,
                     input logic [31:0] x2, input logic [31:0] x3);
    logic [5:0] ra [4];
    ra[0] = r0; ra[1] = r1; ra[2] = r2; ra[3] = r3;
    @(negedge clk);
    check_val("ready_c0", o_req_ready, 1'b1);
    i_req_valid = 1'b1;
    i_wr_en_0 = e0; i_wr_en_1 = e1;
    i_wr_addr_0 = wa0; i_wr_addr_1 = wa1;
    i_wr_data_0 = wd0; i_wr_data_1 = wd1;
    i_rd_addr_0 = r0; i_rd_addr_1 = r1; i_rd_addr_2 = r2; i_rd_addr_3 = r3;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        scramble_inputs();
        check_val("wr_wen", o_ram_wen, xwen);
        check_val("wr_addr_a", o_ram_addr_a, xa);
        check_val("wr_addr_b", o_ram_addr_b, xb);
        check_val("wr_data_a", o_ram_wr_data_a, xda);
        check_val("wr_data_b", o_ram_wr_data_b, xdb);
      end
      if (c >= 2 && c <= 5) begin
        check_val("rd_addr_a", o_ram_addr_a, ra[c-2]);
        check_val("rd_addr_b", o_ram_addr_b, 6'd0);
        check_val("rd_wen", o_ram_wen, 1'b0);
      end
      if (c <= 6) begin
        check_val("busy_ready", o_req_ready, 1'b0);
        check_val("busy_valid", o_rd_valid, 1'b0);
      end
      if (c == 7) begin
        check_val("c7_valid", o_rd_valid, 1'b1);
        check_val("c7_ready", o_req_ready, 1'b1);
        check_val("opnd0", o_rd_data_0, x0);
        check_val("opnd1", o_rd_data_1, x1);
        check_val("opnd2", o_rd_data_2, x2);
        check_val("opnd3", o_rd_data_3, x3);
      end
      if (c == 8) begin
        check_val("c8_valid", o_rd_valid, 1'b0);
        check_val("hold_opnd0", o_rd_data_0, x0);
      end
    end
  endtask

  logic [23:0] req_q [$];
  logic [5:0]  pat [6];
  logic [23:0] req;
  int          pulses;

  initial begin
    pat[0] = 6'd3; pat[1] = 6'd5; pat[2] = 6'd7; pat[3] = 6'd9; pat[4] = 6'd0; pat[5] = 6'd1;
    scramble_inputs();
    i_wr_en_0 = 1'b0; i_wr_en_1 = 1'b0;
    i_reset = 1'b1;
    ram_clr = 1'b1;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    ram_clr = 1'b0;

    check_val("rst_ready", o_req_ready, 1'b1);
    check_val("rst_valid", o_rd_valid, 1'b0);
    check_val("rst_wen", o_ram_wen, 1'b0);
    check_val("rst_addr_a", o_ram_addr_a, 6'd0);
    check_val("rst_addr_b", o_ram_addr_b, 6'd0);
    check_val("rst_wdata_a", o_ram_wr_data_a, 32'h0);
    check_val("rst_wdata_b", o_ram_wr_data_b, 32'h0);
    check_val("rst_opnd0", o_rd_data_0, 32'h0);
    check_val("rst_opnd3", o_rd_data_3, 32'h0);

    // No writes, reads of a cleared RAM.
    txn(1'b0, 1'b0, 6'd0, 6'd0, 32'h0, 32'h0, 6'd1, 6'd2, 6'd3, 6'd4,
        1'b0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    // Two writes to different addresses, read back with read-after-write.
    txn(1'b1, 1'b1, 6'd5, 6'd9, 32'hDEADBEEF, 32'h12345678, 6'd5, 6'd9, 6'd5, 6'd0,
        1'b1, 6'd5, 6'd9, 32'hDEADBEEF, 32'h12345678,
        32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h0);
    // Both writes to one address: write 1 wins.
    txn(1'b1, 1'b1, 6'd7, 6'd7, 32'hAAAA0000, 32'h5555FFFF, 6'd7, 6'd7, 6'd7, 6'd7,
        1'b1, 6'd7, 6'd7, 32'h5555FFFF, 32'h5555FFFF,
        32'h5555FFFF, 32'h5555FFFF, 32'h5555FFFF, 32'h5555FFFF);
    // Only write 1 enabled.
    txn(1'b0, 1'b1, 6'd20, 6'd3, 32'h11111111, 32'h0F0F0F0F, 6'd3, 6'd0, 6'd0, 6'd0,
        1'b1, 6'd3, 6'd3, 32'h0F0F0F0F, 32'h0F0F0F0F,
        32'h0F0F0F0F, 32'h0, 32'h0, 32'h0);
    // Only write 0 enabled, read back and a previously written location.
    txn(1'b1, 1'b0, 6'd11, 6'd40, 32'h600DF00D, 32'h22222222, 6'd11, 6'd9, 6'd40, 6'd11,
        1'b1, 6'd11, 6'd11, 32'h600DF00D, 32'h600DF00D,
        32'h600DF00D, 32'h12345678, 32'h0, 32'h600DF00D);

    // Request held valid with inputs changing every cycle: accepted only in IDLE.
    i_wr_en_0 = 1'b0; i_wr_en_1 = 1'b0;
    for (int n = 0; n <= 28; n++) begin
      @(negedge clk);
      check_val("strm_valid", o_rd_valid, (n % 7 == 0) && (n > 0));
      if (o_rd_valid) begin
        if (req_q.size() == 0) check_val("strm_unexpected", 32'd1, 32'd0);
        else begin
          req = req_q.pop_front();
          check_val("strm_opnd0", o_rd_data_0, exp_mem(req[23:18]));
          check_val("strm_opnd1", o_rd_data_1, exp_mem(req[17:12]));
          check_val("strm_opnd2", o_rd_data_2, exp_mem(req[11:6]));
          check_val("strm_opnd3", o_rd_data_3, exp_mem(req[5:0]));
        end
      end
      check_val("strm_ready", o_req_ready, (n % 7 == 0));
      i_req_valid = (n <= 21);
      i_rd_addr_0 = pat[n % 6];
      i_rd_addr_1 = pat[(n + 1) % 6];
      i_rd_addr_2 = pat[(n + 2) % 6];
      i_rd_addr_3 = pat[(n + 3) % 6];
      if (o_req_ready && i_req_valid)
        req_q.push_back({i_rd_addr_0, i_rd_addr_1, i_rd_addr_2, i_rd_addr_3});
    end
    check_val("strm_drained", req_q.size(), 32'd0);

    // Reset in RD2 of a write-carrying request.
    @(negedge clk);
    i_req_valid = 1'b1;
    i_wr_en_0 = 1'b1; i_wr_en_1 = 1'b0;
    i_wr_addr_0 = 6'd12; i_wr_data_0 = 32'hCAFEF00D;
    i_rd_addr_0 = 6'd12; i_rd_addr_1 = 6'd12; i_rd_addr_2 = 6'd12; i_rd_addr_3 = 6'd12;
    @(negedge clk);
    scramble_inputs();
    repeat (3) @(negedge clk);
    check_val("pre_rst_opnd0", o_rd_data_0, 32'hCAFEF00D);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check_val("mid_rst_ready", o_req_ready, 1'b1);
    check_val("mid_rst_valid", o_rd_valid, 1'b0);
    check_val("mid_rst_wen", o_ram_wen, 1'b0);
    check_val("mid_rst_opnd0", o_rd_data_0, 32'h0);
    check_val("mid_rst_opnd1", o_rd_data_1, 32'h0);
    check_val("mid_rst_opnd2", o_rd_data_2, 32'h0);
    check_val("mid_rst_opnd3", o_rd_data_3, 32'h0);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_rd_valid) pulses++;
    end
    check_val("mid_rst_no_pulse", pulses, 32'd0);
    txn(1'b0, 1'b0, 6'd0, 6'd0, 32'h0, 32'h0, 6'd12, 6'd5, 6'd0, 6'd12,
        1'b0, 6'd0, 6'd0, 32'h0, 32'h0,
        32'hCAFEF00D, 32'hDEADBEEF, 32'h0, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
